// File: rtl/spare_alloc_sequencer_pkg.sv
// Shared constants, candidate tables and FSM encoding for the spare allocation
// sequencer and its combinational helpers.
package spare_alloc_sequencer_pkg;

  localparam logic [1:0] STRUCT1 = 2'd1;
  localparam logic [1:0] STRUCT2 = 2'd2;
  localparam logic [1:0] STRUCT3 = 2'd3;

  localparam logic [7:0] DSSS_FIRST = 8'h0F;
  localparam logic [7:0] DSSS_LAST  = 8'hF0;

  // RLSS candidates in search order; entry 0 is tried first
  localparam logic [5:0][3:0] RLSS_SEQ = {4'hC, 4'hA, 4'h9, 4'h6, 4'h5, 4'h3};
  localparam logic [2:0] RLSS_LAST_IDX = 3'd5;

  localparam logic [8:0] MAX_ATTEMPTS = 9'd420;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  function automatic logic [3:0] rlss_at(input logic [2:0] idx);
    logic [3:0] val;
    val = 4'h0;
    for (int i = 0; i < 6; i++) begin
      if (idx == 3'(i)) val = RLSS_SEQ[i];
    end
    return val;
  endfunction

endpackage

// File: rtl/spare_alloc_sequencer_dsss_comb_next.sv
// Combinational successor of a byte: the next larger value with the same
// number of set bits (used to walk the four-ones DSSS space in order).
module dsss_comb_next
(
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  logic [3:0] tz;
  logic [7:0] fill;
  logic [7:0] carry;
  logic [7:0] tail;

  // Fill the trailing zeros, ripple the lowest run upward, then re-pack the
  // leftover ones at the bottom of the byte.
  always_comb begin
    tz = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (cur[i]) tz = 4'(i);
    end
    fill  = cur | (cur - 8'd1);
    carry = fill + 8'd1;
    tail  = ((~fill & carry) - 8'd1) >> (tz + 4'd1);
    nxt   = carry | tail;
  end

endmodule

// File: rtl/spare_alloc_sequencer.sv
// Walks every DSSS/RLSS spare candidate through an external validity checker
// and reports the first candidate the checker accepts.
module spare_alloc_sequencer
#(
  parameter int CHK_LAT = 1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] spare_struct,
  input  logic       chk_valid,
  output logic [7:0] dsss,
  output logic [3:0] rlss,
  output logic [1:0] struct_sel,
  output logic       cand_valid,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       err,
  output logic [7:0] sol_dsss,
  output logic [3:0] sol_rlss,
  output logic [8:0] attempts
);

  import spare_alloc_sequencer_pkg::*;

  localparam int WCW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam logic [WCW-1:0] LAT_LAST = WCW'(CHK_LAT - 1);

  state_e         state_q, state_d;
  logic [1:0]     struct_sel_q, struct_sel_d;
  logic [7:0]     dsss_q, dsss_d;
  logic [3:0]     rlss_q, rlss_d;
  logic [2:0]     rlss_idx_q, rlss_idx_d;
  logic [8:0]     attempts_q, attempts_d;
  logic           found_q, found_d;
  logic           err_q, err_d;
  logic [7:0]     sol_dsss_q, sol_dsss_d;
  logic [3:0]     sol_rlss_q, sol_rlss_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]     dsss_next;
  logic           last_cand;

  dsss_comb_next u_dsss_next (
    .cur (dsss_q),
    .nxt (dsss_next)
  );

  assign last_cand = (dsss_q == DSSS_LAST) && (rlss_idx_q == RLSS_LAST_IDX);

  always_comb begin
    state_d      = state_q;
    struct_sel_d = struct_sel_q;
    dsss_d       = dsss_q;
    rlss_d       = rlss_q;
    rlss_idx_d   = rlss_idx_q;
    attempts_d   = attempts_q;
    found_d      = found_q;
    err_d        = err_q;
    sol_dsss_d   = sol_dsss_q;
    sol_rlss_d   = sol_rlss_q;
    wait_cnt_d   = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          attempts_d = 9'd0;
          found_d    = 1'b0;
          if (spare_struct != 2'd0) begin
            struct_sel_d = spare_struct;
            dsss_d       = DSSS_FIRST;
            rlss_idx_d   = 3'd0;
            rlss_d       = rlss_at(3'd0);
            err_d        = 1'b0;
            state_d      = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAT_LAST) state_d = ST_EVAL;
        else wait_cnt_d = wait_cnt_q + 1'b1;
      end
      // First accepted candidate wins; otherwise RLSS is the inner loop
      ST_EVAL: begin
        attempts_d = attempts_q + 9'd1;
        if (chk_valid) begin
          sol_dsss_d = dsss_q;
          sol_rlss_d = rlss_q;
          found_d    = 1'b1;
          state_d    = ST_FIN;
        end else if (last_cand) begin
          found_d = 1'b0;
          state_d = ST_FIN;
        end else begin
          if (rlss_idx_q == RLSS_LAST_IDX) begin
            rlss_idx_d = 3'd0;
            dsss_d     = dsss_next;
          end else begin
            rlss_idx_d = rlss_idx_q + 3'd1;
          end
          rlss_d  = rlss_at(rlss_idx_d);
          state_d = ST_ISSUE;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      struct_sel_q <= 2'd0;
      dsss_q       <= 8'h00;
      rlss_q       <= 4'h0;
      rlss_idx_q   <= 3'd0;
      attempts_q   <= 9'd0;
      found_q      <= 1'b0;
      err_q        <= 1'b0;
      sol_dsss_q   <= 8'h00;
      sol_rlss_q   <= 4'h0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      struct_sel_q <= struct_sel_d;
      dsss_q       <= dsss_d;
      rlss_q       <= rlss_d;
      rlss_idx_q   <= rlss_idx_d;
      attempts_q   <= attempts_d;
      found_q      <= found_d;
      err_q        <= err_d;
      sol_dsss_q   <= sol_dsss_d;
      sol_rlss_q   <= sol_rlss_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign dsss       = dsss_q;
  assign rlss       = rlss_q;
  assign struct_sel = struct_sel_q;
  assign cand_valid = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_FIN);
  assign found      = found_q;
  assign err        = err_q;
  assign sol_dsss   = sol_dsss_q;
  assign sol_rlss   = sol_rlss_q;
  assign attempts   = attempts_q;

endmodule
